// File: rtl/leb128_decoder_if.sv
// leb128_decoder_if: handshake and result bundle between the instruction byte
// stream, the LEB128 decoder and the execute stage.
//   master : drives start/mode bits, the input byte stream and out_ready
//   slave  : the decoder; returns in_ready, the decoded result and busy
interface leb128_decoder_if #(
  parameter int DW = 64,
  parameter int LW = 4
);
  logic          start;
  logic          is_signed;
  logic          is_32;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_len;
  logic          out_error;
  logic          busy;

  modport master (
    output start, is_signed, is_32, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_error, busy
  );

  modport slave (
    input  start, is_signed, is_32, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_len, out_error, busy
  );
endinterface

// File: rtl/leb128_decoder.sv
// leb128_decoder: sequential LEB128 immediate decoder, one byte per cycle.
// Decodes signed/unsigned values at 32- or 64-bit width into a 64-bit result
// plus its encoded length, and flags over-long or non-canonical encodings.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : leb128_decoder_if.slave (start/mode, byte stream in, result out)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; mode bits latched on start
// S_DECODE | accepting bytes (in_ready=1) until a final byte or length limit
// S_DONE   | result held on out_valid until out_ready
module leb128_decoder #(
  parameter int DW = 64,
  parameter int LW = 4
) (
  input logic              clk,
  input logic              reset,
  leb128_decoder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE} state_t;

  localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] MAX_32  = LW'(5);
  localparam logic [LW-1:0] MAX_64  = LW'(10);

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [6:0]    shift_q, shift_d;
  logic [LW-1:0] count_q, count_d;
  logic          signed_q, signed_d;
  logic          is32_q, is32_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [LW-1:0] out_len_q, out_len_d;
  logic          out_error_q, out_error_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          cont;
  logic          last_slot;
  logic          finish;
  logic          canon_bad;
  logic          dec_err;
  logic [LW-1:0] count_inc;
  logic [6:0]    sh7;
  logic [DW-1:0] acc_add;
  logic [DW-1:0] low_mask;
  logic [DW-1:0] n_mask;
  logic [DW-1:0] value_n;
  logic [DW-1:0] value_ext;

  assign accept    = (state_q == S_DECODE) && bus.in_valid;
  assign cont      = bus.in_data[7];
  assign count_inc = count_q + 1'b1;
  assign last_slot = (count_inc == (is32_q ? MAX_32 : MAX_64));
  // A byte ends the decode either by clearing continuation or by hitting the limit.
  assign finish    = !cont || last_slot;
  assign sh7       = shift_q + 7'd7;
  assign acc_add   = acc_q | ({{(DW-7){1'b0}}, bus.in_data[6:0]} << shift_q);

  // Sign fill covers [N-1 : shift+7]; nothing to fill once shift+7 reaches N.
  assign low_mask  = (sh7 >= 7'd64) ? '1 : ((ONE << sh7) - ONE);
  assign n_mask    = is32_q ? {{(DW-32){1'b0}}, {32{1'b1}}} : '1;
  assign value_n   = acc_add | ((signed_q && bus.in_data[6]) ? (~low_mask & n_mask) : '0);
  assign value_ext = is32_q ? {{(DW-32){signed_q & value_n[31]}}, value_n[31:0]} : value_n;

  // Only the byte in the last slot can carry bits beyond the target width.
  always_comb begin
    canon_bad = 1'b0;
    case ({is32_q, signed_q})
      2'b10:   canon_bad = |bus.in_data[6:4];
      2'b11:   canon_bad = !((bus.in_data[6:3] == 4'h0) || (bus.in_data[6:3] == 4'hF));
      2'b00:   canon_bad = |bus.in_data[6:1];
      default: canon_bad = !((bus.in_data[6:0] == 7'h00) || (bus.in_data[6:0] == 7'h7F));
    endcase
  end

  assign dec_err = last_slot && (cont || canon_bad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start)          state_d = S_DECODE;
      S_DECODE: if (accept && finish)   state_d = S_DONE;
      S_DONE:   if (bus.out_ready)      state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    shift_d     = shift_q;
    count_d     = count_q;
    signed_d    = signed_q;
    is32_d      = is32_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_error_d = out_error_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          shift_d  = '0;
          count_d  = '0;
          signed_d = bus.is_signed;
          is32_d   = bus.is_32;
        end
      end
      S_DECODE: begin
        if (accept) begin
          acc_d   = acc_add;
          shift_d = sh7;
          count_d = count_inc;
          if (finish) begin
            out_valid_d = 1'b1;
            out_len_d   = count_inc;
            out_error_d = dec_err;
            out_data_d  = dec_err ? '0 : value_ext;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      signed_q    <= 1'b0;
      is32_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      signed_q    <= signed_d;
      is32_q      <= is32_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_error_q <= out_error_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == S_DECODE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_error = out_error_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/leb128_decoder.md
# leb128_decoder

Sequential LEB128 immediate decoder sitting between the instruction ROM byte stream and the CPU execute stage. It consumes one byte per cycle over a valid/ready handshake and produces a single 64-bit immediate with its encoded length. It supports signed and unsigned modes at 32- and 64-bit widths, and flags over-long or non-canonical encodings as an error the CPU turns into a trap.

## Interface
- `DW`, default 64: output data width; fixed at 64, any other value is unsupported.
- `LW`, default 4: width of the encoded-length output.
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a decode; sampled only in IDLE.
- `is_signed`, in, 1: signed (varsN) mode; captured on `start`.
- `is_32`, in, 1: 32-bit mode, max 5 bytes (otherwise 64-bit, max 10 bytes); captured on `start`.
- `in_valid`, in, 1: `in_data` holds a byte.
- `in_data`, in, 8: encoded byte; bit 7 is the continuation flag.
- `in_ready`, out, 1: decoder accepts a byte this cycle.
- `out_valid`, out, 1: result available; held until accepted.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, 64: decoded value, extended to 64 bits.
- `out_len`, out, LW: number of bytes consumed, 1..10.
- `out_error`, out, 1: encoding invalid; qualified by `out_valid`.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- States: IDLE, DECODE, DONE.
- IDLE, on `start`: clear accumulator, shift, count; latch the mode bits; go to DECODE.
- DECODE:
  - On each accepted byte (`in_valid && in_ready`): `acc |= in_data[6:0] << shift`, `shift += 7`, `count += 1`.
  - Accumulator bits above bit 63 are discarded.
- Termination, when `in_data[7]==0`:
  - Signed mode with `in_data[6]==1` and `shift+7 < N` (N = 32 or 64): fill bits `[N-1 : shift+7]` with 1.
  - 32-bit mode: `out_data[63:32]` = copy of bit 31 when signed, zero when unsigned.
  - Go to DONE.
- Length limit: continuation still set on byte 5 (32-bit) or byte 10 (64-bit) sets `out_error` and goes to DONE. No further bytes are consumed.
- Canonical check on the final byte:
  - 32-bit unsigned: bits `[6:4]` must be 0.
  - 32-bit signed: bits `[6:3]` must be all 0 or all 1.
  - 64-bit unsigned: bits `[6:1]` must be 0.
  - 64-bit signed: byte must be 0x00 or 0x7F.
  - A violation sets `out_error`.
- Outputs on error: `out_data=0`, `out_len` = bytes consumed.
- DONE: `out_valid=1`. When `out_ready` is high, go to IDLE. `start` is ignored in DECODE and DONE.
- Reset values: state IDLE; `in_ready`, `out_valid`, `out_error`, `busy` = 0; `out_data` = 0; `out_len` = 0; accumulator cleared.

## Timing
- `in_ready` is combinational: `state==DECODE`.
- All other outputs are registered.
- Latency: `start` accepted in cycle 0; bytes accepted in cycles 1..N with `in_valid` held high; `out_valid` rises in cycle N+1.
- Back-to-back decodes: the DONE→IDLE handshake takes one cycle, so the next `start` is accepted in the cycle after `out_ready`. Minimum period is N+2 cycles.
- `in_valid` low in DECODE stalls with no state change. `out_ready` low holds `out_valid`, `out_data` and `out_len` stable.
- Reset mid-decode: immediate return to IDLE with all outputs cleared. The partially consumed bytes are not replayed.

## Test plan
- Unsigned 64-bit, bytes E5 8E 26 → `out_data`=624485, `out_len`=3, `out_error`=0, `out_valid` 4 cycles after `start`.
- Signed 64-bit, bytes C0 BB 78 → `out_data`=0xFFFF_FFFF_FFFE_1DC0 (−123456), `out_len`=3.
- Signed 32-bit, byte 7F → `out_data`=0xFFFF_FFFF_FFFF_FFFF, `out_len`=1. Unsigned 32-bit, byte 7F → `out_data`=127.
- Unsigned 32-bit, bytes FF FF FF FF 10 → `out_error`=1, `out_data`=0, `out_len`=5. Signed 64-bit, ten bytes of 0x80 → `out_error`=1, `out_len`=10, 11th byte not consumed (`in_ready`=0).
- Backpressure and stall:
  - Drop `in_valid` for 3 cycles mid-decode → result unchanged, latency +3.
  - Hold `out_ready`=0 for 5 cycles → outputs stable; `start` during DONE ignored.
- Reset asserted after 2 bytes of a 3-byte encoding → next cycle `busy`=0, `out_valid`=0. A fresh `start` with 02 → `out_data`=2, `out_len`=1.
